// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: control-word pipeline (ID/EX -> EX/MEM -> MEM/WB ...)
// carrying decoded control words and their valid bits through STAGES
// registers. It supports bubble insertion, stall (hold stage 0 and inject
// a bubble behind it) and flush of the youngest FLUSH_DEPTH stages.
// Priority at each edge: Clr, flush, stall, normal advance.
// An invalid stage always holds an all-zero word.
//
// Optional feature: define CTRL_PIPE_PERF_EN to build the saturating
// bubble_count performance counter. Without it, bubble_count is tied to 0
// and no counter register exists.
//
// Parameter ranges: W 1..64, STAGES 2..8, FLUSH_DEPTH 1..STAGES-1.
module ctrl_pipe_chain #(
  parameter int W           = 16,
  parameter int STAGES      = 3,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic                  Clk,
  input  logic                  Clr,
  input  logic [W-1:0]          in_ctrl,
  input  logic                  in_valid,
  input  logic                  bubble,
  input  logic                  stall,
  input  logic                  flush,
  output logic [STAGES*W-1:0]   stage_ctrl,
  output logic [STAGES-1:0]     stage_valid,
  output logic [3:0]            valid_count,
  output logic [7:0]            bubble_count
);

  logic [W-1:0]      word_q [STAGES];
  logic [W-1:0]      word_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;

  // Next-state selection: start from a plain shift, then let stall and
  // flush override the stages they own (flush wins over stall).
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      word_d[i]  = '0;
      valid_d[i] = 1'b0;
    end
    if (in_valid && !bubble) begin
      word_d[0]  = in_ctrl;
      valid_d[0] = 1'b1;
    end
    for (int i = 1; i < STAGES; i++) begin
      word_d[i]  = word_q[i-1];
      valid_d[i] = valid_q[i-1];
    end
    if (flush) begin
      for (int i = 0; i < FLUSH_DEPTH; i++) begin
        word_d[i]  = '0;
        valid_d[i] = 1'b0;
      end
    end else if (stall) begin
      word_d[0]  = word_q[0];
      valid_d[0] = valid_q[0];
      word_d[1]  = '0;
      valid_d[1] = 1'b0;
    end
  end

  // Stage registers with synchronous clear.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      for (int i = 0; i < STAGES; i++) begin
        word_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        word_q[i] <= word_d[i];
      end
      valid_q <= valid_d;
    end
  end

  // Flatten stage words onto the output bus and count live stages.
  always_comb begin
    stage_ctrl  = '0;
    valid_count = '0;
    for (int i = 0; i < STAGES; i++) begin
      stage_ctrl[i*W +: W] = word_q[i];
      valid_count          = valid_count + {3'b000, valid_q[i]};
    end
  end

  assign stage_valid = valid_q;

`ifdef CTRL_PIPE_PERF_EN
  logic [7:0] bubble_cnt_q;

  // Saturating count of edges that inserted a bubble by any means.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      bubble_cnt_q <= 8'd0;
    end else if ((flush || stall || bubble) && (bubble_cnt_q != 8'hFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 8'd1;
    end
  end

  assign bubble_count = bubble_cnt_q;
`else
  assign bubble_count = 8'd0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb_ctrl_pipe_chain: directed bench for ctrl_pipe_chain (W=16, STAGES=3,
// FLUSH_DEPTH=1). A queue-style reference model tracks the pipeline; a
// compare process checks every output on each falling edge once the model
// state is known, and literal checks pin the model to hand-computed values.
// Works with or without CTRL_PIPE_PERF_EN.
module tb_ctrl_pipe_chain;

  localparam int W  = 16;
  localparam int S  = 3;
  localparam int FD = 1;
`ifdef CTRL_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic           Clk = 1'b0;
  logic           Clr = 1'b0;
  logic [W-1:0]   in_ctrl = '0;
  logic           in_valid = 1'b0;
  logic           bubble = 1'b0;
  logic           stall = 1'b0;
  logic           flush = 1'b0;
  logic [S*W-1:0] stage_ctrl;
  logic [S-1:0]   stage_valid;
  logic [3:0]     valid_count;
  logic [7:0]     bubble_count;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [W-1:0] m_word [S];
  logic         m_valid [S];
  int           m_bubbles = 0;
  bit           m_known = 1'b0;

  ctrl_pipe_chain #(.W(W), .STAGES(S), .FLUSH_DEPTH(FD)) dut (
    .Clk(Clk), .Clr(Clr), .in_ctrl(in_ctrl), .in_valid(in_valid),
    .bubble(bubble), .stall(stall), .flush(flush),
    .stage_ctrl(stage_ctrl), .stage_valid(stage_valid),
    .valid_count(valid_count), .bubble_count(bubble_count)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: the pipeline is a list of slots; each edge builds the new list
  // from the rule for the highest-priority active control.
  always @(posedge Clk) begin
    logic [W-1:0] nw [S];
    logic         nv [S];
    if (Clr) begin
      for (int i = 0; i < S; i++) begin m_word[i] = '0; m_valid[i] = 1'b0; end
      m_bubbles = 0;
      m_known   = 1'b1;
    end else begin
      for (int i = 1; i < S; i++) begin nw[i] = m_word[i-1]; nv[i] = m_valid[i-1]; end
      nv[0] = in_valid && !bubble;
      nw[0] = nv[0] ? in_ctrl : '0;
      if (flush) begin
        for (int i = 0; i < FD; i++) begin nw[i] = '0; nv[i] = 1'b0; end
      end else if (stall) begin
        nw[0] = m_word[0]; nv[0] = m_valid[0];
        nw[1] = '0;        nv[1] = 1'b0;
      end
      for (int i = 0; i < S; i++) begin m_word[i] = nw[i]; m_valid[i] = nv[i]; end
      if ((flush || stall || bubble) && m_bubbles < 255) m_bubbles++;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge Clk) begin
    if (m_known) begin
      int cnt;
      logic [S-1:0] mv;
      cnt = 0;
      for (int i = 0; i < S; i++) begin
        checkOutput($sformatf("cyc stage%0d word", i), 64'(stage_ctrl[i*W +: W]), 64'(m_word[i]));
        mv[i] = m_valid[i];
        cnt += m_valid[i] ? 1 : 0;
      end
      checkOutput("cyc stage_valid", 64'(stage_valid), 64'(mv));
      checkOutput("cyc valid_count", 64'(valid_count), 64'(cnt));
      checkOutput("cyc bubble_count", 64'(bubble_count), PERF ? 64'(m_bubbles) : 64'd0);
    end
  end

  // Drive one edge worth of inputs, then wait just past that edge.
  task automatic applyStimulus(input logic clr, input logic [W-1:0] ctrl, input logic vld,
                               input logic bub, input logic stl, input logic fl);
    Clr = clr; in_ctrl = ctrl; in_valid = vld; bubble = bub; stall = stl; flush = fl;
    @(posedge Clk);
    #2;
  endtask

  function automatic logic [W-1:0] stg(input int i);
    return stage_ctrl[i*W +: W];
  endfunction

  initial begin
    // Reset for two edges
    @(negedge Clk);
    applyStimulus(1, 16'hDEAD, 1, 0, 1, 0);
    applyStimulus(1, 16'hBEEF, 1, 0, 0, 1);
    checkOutput("reset stage_ctrl", 64'(stage_ctrl), 64'd0);
    checkOutput("reset stage_valid", 64'(stage_valid), 64'd0);
    checkOutput("reset bubble_count", 64'(bubble_count), 64'd0);

    // Fill: latency i+1 to stage i
    applyStimulus(0, 16'h1111, 1, 0, 0, 0);
    checkOutput("fill1 stage0", 64'(stg(0)), 64'h1111);
    applyStimulus(0, 16'h2222, 1, 0, 0, 0);
    applyStimulus(0, 16'h3333, 1, 0, 0, 0);
    checkOutput("fill stage2", 64'(stg(2)), 64'h1111);
    checkOutput("fill stage1", 64'(stg(1)), 64'h2222);
    checkOutput("fill stage0", 64'(stg(0)), 64'h3333);
    checkOutput("fill valid_count", 64'(valid_count), 64'd3);

    // Stall with stage0 = AAAA
    applyStimulus(0, 16'hAAAA, 1, 0, 0, 0);
    applyStimulus(0, 16'hBBBB, 1, 0, 1, 0);
    checkOutput("stall stage0", 64'(stg(0)), 64'hAAAA);
    checkOutput("stall stage1", 64'(stg(1)), 64'h0);
    checkOutput("stall stage2", 64'(stg(2)), 64'h3333);
    checkOutput("stall valid", 64'(stage_valid), 64'b101);
    checkOutput("stall bubble_count", 64'(bubble_count), PERF ? 64'd1 : 64'd0);

    // Flush + stall together: stall ignored
    applyStimulus(0, 16'hCCCC, 1, 0, 0, 0);
    applyStimulus(0, 16'hDDDD, 1, 1, 1, 1);
    checkOutput("flush stage0", 64'(stg(0)), 64'h0);
    checkOutput("flush stage1", 64'(stg(1)), 64'hCCCC);
    checkOutput("flush stage2", 64'(stg(2)), 64'hAAAA);
    checkOutput("flush valid", 64'(stage_valid), 64'b110);

    // Invalid input without bubble: word forced to zero
    applyStimulus(0, 16'hFFFF, 0, 0, 0, 0);
    checkOutput("invalid-in stage0", 64'(stg(0)), 64'h0);
    checkOutput("invalid-in valid", 64'(stage_valid), 64'b100);
    checkOutput("invalid-in stage2", 64'(stg(2)), 64'hCCCC);

    // Bubble held for 300 edges: drains and saturates
    for (int k = 1; k <= 300; k++) begin
      applyStimulus(0, 16'h5555, 1, 1, 0, 0);
      if (k == 3) begin
        checkOutput("bubble drain ctrl", 64'(stage_ctrl), 64'd0);
        checkOutput("bubble drain count", 64'(valid_count), 64'd0);
      end
      if (k == 252) checkOutput("bubble cnt 254", 64'(bubble_count), PERF ? 64'd254 : 64'd0);
    end
    checkOutput("bubble cnt sat", 64'(bubble_count), PERF ? 64'd255 : 64'd0);

    // Clr during a two-cycle stall
    applyStimulus(0, 16'h7001, 1, 0, 0, 0);
    applyStimulus(0, 16'h7002, 1, 0, 0, 0);
    applyStimulus(0, 16'h7003, 1, 0, 0, 0);
    checkOutput("prefill valid_count", 64'(valid_count), 64'd3);
    applyStimulus(0, 16'h7004, 1, 0, 1, 0);
    applyStimulus(1, 16'h7005, 1, 0, 1, 0);
    checkOutput("clr ctrl", 64'(stage_ctrl), 64'd0);
    checkOutput("clr valid", 64'(stage_valid), 64'd0);
    checkOutput("clr bubble_count", 64'(bubble_count), 64'd0);
    applyStimulus(0, 16'h4444, 1, 0, 0, 0);
    checkOutput("post-clr stage0", 64'(stg(0)), 64'h4444);
    checkOutput("post-clr valid", 64'(stage_valid), 64'b001);

    // Mixed directed sequence checked by the model each cycle
    applyStimulus(0, 16'h0101, 1, 0, 0, 0);
    applyStimulus(0, 16'h0202, 1, 0, 1, 0);
    applyStimulus(0, 16'h0303, 1, 0, 1, 0);
    applyStimulus(0, 16'h0404, 0, 0, 0, 0);
    applyStimulus(0, 16'h0505, 1, 0, 0, 1);
    applyStimulus(0, 16'h0606, 1, 1, 0, 0);
    applyStimulus(0, 16'h0707, 1, 0, 0, 0);
    applyStimulus(0, 16'h0808, 1, 0, 0, 0);
    checkOutput("mix stage1", 64'(stg(1)), 64'h0707);
    checkOutput("mix stage0", 64'(stg(0)), 64'h0808);
    checkOutput("mix valid", 64'(stage_valid), 64'b011);

    @(negedge Clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
